// File: rtl/gcd_pkg.sv
// Shared types and constants for the GCD job sequencer.
package gcd_pkg;

  localparam int unsigned OP_SZ_DEF = 8;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT,
    CAPT,
    OUT
  } seq_state_e;

  // Width of a counter that must be able to hold the value `timeout`.
  function automatic int unsigned tmo_cnt_w(input int unsigned timeout);
    return $clog2(timeout + 1);
  endfunction

  localparam int unsigned TMO_CNT_W_DEF = tmo_cnt_w(1024);

endpackage

// File: rtl/gcd_seq_fifo.sv
// Synchronous FIFO of {a,b} operand pairs; pointers carry a wrap bit for full/empty.
module gcd_seq_fifo #(
  parameter int unsigned W     = 16,
  parameter int unsigned DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push_i,
  input  logic [W-1:0] data_i,
  input  logic         pop_i,
  output logic [W-1:0] data_o,
  output logic         full_o,
  output logic         empty_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW:0]  wr_ptr_q, wr_ptr_d;
  logic [AW:0]  rd_ptr_q, rd_ptr_d;
  logic [W-1:0] mem_q [DEPTH];
  logic         do_push;
  logic         do_pop;

  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  // A full FIFO refuses a push even if the head is popped in the same cycle.
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign data_o  = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q + (AW + 1)'(do_push);
    rd_ptr_d = rd_ptr_q + (AW + 1)'(do_pop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= data_i;
    end
  end

endmodule

// File: rtl/gcd_job_sequencer.sv
// Buffers operand pairs and runs them one at a time through the subtraction GCD core.
// Define GCD_SEQ_TIMEOUT_EN to abort jobs whose core never signals done.
module gcd_job_sequencer
  import gcd_pkg::*;
#(
  parameter int unsigned OP_SZ      = OP_SZ_DEF,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned TIMEOUT    = 1024
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OP_SZ-1:0] in_a,
  input  logic [OP_SZ-1:0] in_b,
  output logic             core_start,
  output logic [OP_SZ-1:0] core_a,
  output logic [OP_SZ-1:0] core_b,
  input  logic             core_done,
  input  logic [OP_SZ-1:0] core_res,
  output logic             core_rst,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OP_SZ-1:0] out_res,
  output logic             out_err
);

  localparam int unsigned PAIR_W = 2 * OP_SZ;

  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("FIFO_DEPTH must be a power of two and at least 2");
  end
  if (TIMEOUT == 0) begin : g_bad_timeout
    $error("TIMEOUT must be at least 1");
  end

  seq_state_e        state_q, state_d;
  logic [OP_SZ-1:0]  op_a_q, op_a_d;
  logic [OP_SZ-1:0]  op_b_q, op_b_d;
  logic [OP_SZ-1:0]  out_res_q, out_res_d;
  logic              out_valid_q, out_valid_d;
  logic              core_start_q, core_start_d;
  logic              fifo_pop;
  logic              fifo_full;
  logic              fifo_empty;
  logic [PAIR_W-1:0] fifo_head;
  logic [OP_SZ-1:0]  head_a;
  logic [OP_SZ-1:0]  head_b;

`ifdef GCD_SEQ_TIMEOUT_EN
  localparam int unsigned CNT_W = tmo_cnt_w(TIMEOUT);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             out_err_q, out_err_d;
  logic             core_rst_q, core_rst_d;
`endif

  gcd_seq_fifo #(
    .W     (PAIR_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (in_valid),
    .data_i  ({in_a, in_b}),
    .pop_i   (fifo_pop),
    .data_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign head_a = fifo_head[PAIR_W-1:OP_SZ];
  assign head_b = fifo_head[OP_SZ-1:0];

  // Next-state and registered-output logic.
  always_comb begin
    state_d      = state_q;
    op_a_d       = op_a_q;
    op_b_d       = op_b_q;
    out_res_d    = out_res_q;
    out_valid_d  = out_valid_q;
    core_start_d = 1'b0;
    fifo_pop     = 1'b0;
`ifdef GCD_SEQ_TIMEOUT_EN
    out_err_d    = out_err_q;
    core_rst_d   = 1'b0;
    cnt_d        = cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          op_a_d   = head_a;
          op_b_d   = head_b;
          // The subtraction core never terminates on a zero operand.
          if (head_a == '0 || head_b == '0) begin
            out_res_d   = head_a | head_b;
            out_valid_d = 1'b1;
            state_d     = OUT;
`ifdef GCD_SEQ_TIMEOUT_EN
            out_err_d   = 1'b0;
`endif
          end else begin
            core_start_d = 1'b1;
            state_d      = ISSUE;
          end
        end
      end
      ISSUE: begin
        state_d = WAIT;
`ifdef GCD_SEQ_TIMEOUT_EN
        cnt_d   = '0;
`endif
      end
      WAIT: begin
        if (core_done) begin
          state_d = CAPT;
`ifdef GCD_SEQ_TIMEOUT_EN
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          core_rst_d  = 1'b1;
          out_res_d   = '0;
          out_err_d   = 1'b1;
          out_valid_d = 1'b1;
          state_d     = OUT;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
`endif
        end
      end
      CAPT: begin
        // core_res is only updated on the edge that sampled done_sig.
        out_res_d   = core_res;
        out_valid_d = 1'b1;
        state_d     = OUT;
`ifdef GCD_SEQ_TIMEOUT_EN
        out_err_d   = 1'b0;
`endif
      end
      OUT: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      op_a_q       <= '0;
      op_b_q       <= '0;
      out_res_q    <= '0;
      out_valid_q  <= 1'b0;
      core_start_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      op_a_q       <= op_a_d;
      op_b_q       <= op_b_d;
      out_res_q    <= out_res_d;
      out_valid_q  <= out_valid_d;
      core_start_q <= core_start_d;
    end
  end

`ifdef GCD_SEQ_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q      <= '0;
      out_err_q  <= 1'b0;
      core_rst_q <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      out_err_q  <= out_err_d;
      core_rst_q <= core_rst_d;
    end
  end

  assign out_err  = out_err_q;
  assign core_rst = core_rst_q;
`else
  assign out_err  = 1'b0;
  assign core_rst = 1'b0;
`endif

  assign in_ready   = !fifo_full;
  assign core_start = core_start_q;
  assign core_a     = op_a_q;
  assign core_b     = op_b_q;
  assign out_valid  = out_valid_q;
  assign out_res    = out_res_q;

endmodule

// File: tb/tb_gcd_job_sequencer.sv
// Randomized bench for gcd_job_sequencer with a behavioural GCD core and result scoreboard.
module tb_gcd_job_sequencer;

  localparam int unsigned OP_SZ      = 8;
  localparam int unsigned FIFO_DEPTH = 4;
  localparam int unsigned TIMEOUT    = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [OP_SZ-1:0] in_a, in_b;
  logic             core_start;
  logic [OP_SZ-1:0] core_a, core_b;
  logic             core_done;
  logic [OP_SZ-1:0] core_res;
  logic             core_rst;
  logic             out_valid;
  logic             out_ready;
  logic [OP_SZ-1:0] out_res;
  logic             out_err;

  gcd_job_sequencer #(
    .OP_SZ      (OP_SZ),
    .FIFO_DEPTH (FIFO_DEPTH),
    .TIMEOUT    (TIMEOUT)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .in_b       (in_b),
    .core_start (core_start),
    .core_a     (core_a),
    .core_b     (core_b),
    .core_done  (core_done),
    .core_res   (core_res),
    .core_rst   (core_rst),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_res    (out_res),
    .out_err    (out_err)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int exp_res[$];
  bit exp_err[$];
  int start_cnt = 0, hs_cnt = 0, crst_cnt = 0, crst_cyc = 0;
  bit stall = 0, never_done = 0, inject_done = 0;
  int ready_mode = 1;
  bit busy = 0;
  int lat = 0;
  logic [OP_SZ-1:0] ca, cb, pend;
  int mon_r;
  bit mon_e;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference GCD: Euclid's algorithm, gcd(x,0)=x.
  function automatic int ref_gcd(input int a, input int b);
    int x, y, t;
    x = a; y = b;
    while (y != 0) begin
      t = x % y; x = y; y = t;
    end
    return x;
  endfunction

  // Behavioural core: result appears on res only after the done cycle.
  initial begin
    core_done = 1'b0;
    core_res  = '0;
    forever begin
      @(negedge clk);
      if (rst === 1'b1 || core_rst === 1'b1) begin
        busy = 0; core_done = 1'b0;
      end else begin
        if (core_done) begin
          core_done = 1'b0; core_res = pend;
        end
        if (core_start === 1'b1) begin
          busy = 1; ca = core_a; cb = core_b;
          lat = $urandom_range(0, 5);
          core_res = OP_SZ'($urandom);
        end else if (busy && !stall && !never_done) begin
          if (lat == 0) begin
            core_done = 1'b1; pend = OP_SZ'(ref_gcd(int'(ca), int'(cb))); busy = 0;
          end else lat--;
        end else if (!busy && inject_done) begin
          core_done = 1'b1; pend = OP_SZ'($urandom); inject_done = 0;
        end
      end
    end
  end

  // Output scoreboard and event counters.
  initial begin
    forever begin
      @(negedge clk);
      if (core_start === 1'b1) start_cnt++;
      if (core_rst === 1'b1) begin crst_cnt++; crst_cyc = cyc; end
      if (out_valid === 1'b1 && out_ready === 1'b1 && rst === 1'b0) begin
        hs_cnt++;
        checks++;
        if (exp_res.size() == 0) begin
          errors++;
          $display("FAIL result_unexpected: got res=%0d err=%0b, required no result", out_res, out_err);
        end else begin
          mon_r = exp_res.pop_front();
          mon_e = exp_err.pop_front();
          if (out_res !== OP_SZ'(mon_r) || out_err !== mon_e) begin
            errors++;
            $display("FAIL result_order: got res=%0d err=%0b, required res=%0d err=%0b",
                     out_res, out_err, mon_r, mon_e);
          end
        end
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #2;
      case (ready_mode)
        0:       out_ready = 1'b0;
        1:       out_ready = 1'b1;
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  initial begin
    #800000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offers one pair; returns in the cycle after it was accepted.
  task automatic push_pair(input int a, input int b, input bit err_exp, output int acc_cyc);
    int n;
    n = 0;
    in_a = OP_SZ'(a); in_b = OP_SZ'(b); in_valid = 1'b1;
    while (in_ready !== 1'b1 && n < 200) begin tick(); n++; end
    if (n >= 200) begin
      checks++; errors++;
      $display("FAIL push_wait: in_ready=%b, required 1", in_ready);
    end
    acc_cyc = cyc;
    exp_res.push_back(err_exp ? 0 : ref_gcd(a, b));
    exp_err.push_back(err_exp);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(input int max);
    int n;
    n = 0;
    while (out_valid !== 1'b1 && n < max) begin tick(); n++; end
    if (n >= max) begin
      checks++; errors++;
      $display("FAIL wait_valid: out_valid=%b after %0d cycles, required 1", out_valid, max);
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_res.size() != 0 || out_valid === 1'b1) && n < 3000) begin tick(); n++; end
    if (n >= 3000) begin
      checks++; errors++;
      $display("FAIL drain: %0d results outstanding, required 0", exp_res.size());
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    checks++;
    if ({out_valid, out_err, core_start, core_rst} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_ctrl: valid/err/start/rst=%b, required 0000", {out_valid, out_err, core_start, core_rst});
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL reset_in_ready: got %b, required 1", in_ready);
    end
    checks++;
    if ({out_res, core_a, core_b} !== '0) begin
      errors++; $display("FAIL reset_data: res=%0d a=%0d b=%0d, required 0", out_res, core_a, core_b);
    end
  endtask

  task automatic test_basic();
    int n, s0, h0;
    ready_mode = 1;
    s0 = start_cnt; h0 = hs_cnt;
    push_pair(48, 18, 0, n);
    tick();
    checks++;
    if (core_start !== 1'b1 || core_a !== 8'd48 || core_b !== 8'd18) begin
      errors++;
      $display("FAIL basic_issue: start=%b a=%0d b=%0d at push+2, required 1/48/18", core_start, core_a, core_b);
    end
    tick();
    checks++;
    if (core_start !== 1'b0) begin
      errors++; $display("FAIL basic_start_width: start=%b at push+3, required 0", core_start);
    end
    drain();
    checks++;
    if (start_cnt - s0 != 1 || hs_cnt - h0 != 1) begin
      errors++;
      $display("FAIL basic_counts: starts=%0d handshakes=%0d, required 1/1", start_cnt - s0, hs_cnt - h0);
    end
  endtask

  task automatic test_zero();
    int n, s0;
    int za[2], zb[2];
    za[0] = 0; zb[0] = 35; za[1] = 0; zb[1] = 0;
    s0 = start_cnt;
    for (int i = 0; i < 2; i++) begin
      push_pair(za[i], zb[i], 0, n);
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_res !== OP_SZ'(za[i] | zb[i]) || out_err !== 1'b0) begin
        errors++;
        $display("FAIL zero_bypass: valid=%b res=%0d err=%b at push+2, required 1/%0d/0",
                 out_valid, out_res, out_err, za[i] | zb[i]);
      end
      drain();
    end
    checks++;
    if (start_cnt != s0) begin
      errors++; $display("FAIL zero_no_start: starts=%0d, required 0", start_cnt - s0);
    end
  endtask

  task automatic test_back_to_back();
    int n, h0;
    int pa[5], pb[5];
    pa = '{12, 9, 7, 10, 255};
    pb = '{8, 6, 5, 10, 51};
    ready_mode = 1;
    stall = 1;
    h0 = hs_cnt;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (in_ready !== 1'b1) begin
        errors++; $display("FAIL b2b_ready_%0d: in_ready=%b, required 1", i, in_ready);
      end
      push_pair(pa[i], pb[i], 0, n);
    end
    // Head job is in flight; the remaining four fill the FIFO.
    checks++;
    if (in_ready !== 1'b0) begin
      errors++; $display("FAIL b2b_full: in_ready=%b, required 0", in_ready);
    end
    repeat (5) tick();
    checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL b2b_stalled: in_ready=%b out_valid=%b, required 0/0", in_ready, out_valid);
    end
    stall = 0;
    drain();
    checks++;
    if (hs_cnt - h0 != 5) begin
      errors++; $display("FAIL b2b_count: handshakes=%0d, required 5", hs_cnt - h0);
    end
  endtask

  task automatic test_out_hold();
    int n, s0, n2;
    logic [OP_SZ-1:0] r0;
    ready_mode = 0;
    tick();
    push_pair(36, 24, 0, n);
    push_pair(21, 14, 0, n);
    wait_valid(100);
    s0 = start_cnt;
    r0 = out_res;
    checks++;
    if (r0 !== 8'd12) begin
      errors++; $display("FAIL hold_first: res=%0d, required 12", r0);
    end
    for (int i = 0; i < 20; i++) begin
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_res !== r0) begin
        errors++;
        $display("FAIL hold_stable: cycle %0d valid=%b res=%0d, required 1/%0d", i, out_valid, out_res, r0);
      end
    end
    checks++;
    if (start_cnt != s0) begin
      errors++; $display("FAIL hold_no_start: starts=%0d, required 0", start_cnt - s0);
    end
    ready_mode = 1;
    n2 = 0;
    while (start_cnt == s0 && n2 < 20) begin tick(); n2++; end
    checks++;
    if (start_cnt == s0) begin
      errors++; $display("FAIL hold_release: starts=%0d after release, required 1", start_cnt - s0);
    end
    drain();
  endtask

  task automatic test_reset_mid();
    int n, h0, s0;
    ready_mode = 1;
    stall = 1;
    for (int i = 0; i < 4; i++) push_pair($urandom_range(1, 255), $urandom_range(1, 255), 0, n);
    repeat (3) tick();
    h0 = hs_cnt;
    rst = 1'b1;
    exp_res.delete();
    exp_err.delete();
    tick();
    rst = 1'b0;
    stall = 0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid: out_valid=%b in_ready=%b, required 0/1", out_valid, in_ready);
    end
    s0 = start_cnt;
    repeat (30) tick();
    checks++;
    if (hs_cnt != h0 || start_cnt != s0) begin
      errors++;
      $display("FAIL rst_stale: handshakes=%0d starts=%0d, required 0/0", hs_cnt - h0, start_cnt - s0);
    end
    push_pair(64, 24, 0, n);
    drain();
    checks++;
    if (hs_cnt - h0 != 1) begin
      errors++; $display("FAIL rst_recover: handshakes=%0d, required 1", hs_cnt - h0);
    end
  endtask

  task automatic test_spurious_done();
    int h0, s0;
    h0 = hs_cnt; s0 = start_cnt;
    inject_done = 1;
    repeat (10) tick();
    checks++;
    if (out_valid !== 1'b0 || hs_cnt != h0 || start_cnt != s0) begin
      errors++;
      $display("FAIL spurious_done: out_valid=%b handshakes=%0d starts=%0d, required 0/0/0",
               out_valid, hs_cnt - h0, start_cnt - s0);
    end
  endtask

  task automatic test_random();
    int n, a, b, h0;
    h0 = hs_cnt;
    ready_mode = 2;
    for (int i = 0; i < 24; i++) begin
      a = ($urandom_range(0, 5) == 0) ? 0 : $urandom_range(1, 255);
      b = ($urandom_range(0, 5) == 0) ? 0 : $urandom_range(1, 255);
      push_pair(a, b, 0, n);
      if ($urandom_range(0, 2) == 0) repeat ($urandom_range(1, 6)) tick();
    end
    drain();
    ready_mode = 1;
    checks++;
    if (hs_cnt - h0 != 24) begin
      errors++; $display("FAIL random_count: handshakes=%0d, required 24", hs_cnt - h0);
    end
  endtask

  task automatic test_timeout();
`ifdef GCD_SEQ_TIMEOUT_EN
    int n, s, c0;
    ready_mode = 0;
    never_done = 1;
    c0 = crst_cnt;
    tick();
    push_pair(40, 30, 1, n);
    s = n + 2;
    wait_valid(100);
    checks++;
    if (out_err !== 1'b1 || out_res !== '0) begin
      errors++; $display("FAIL tmo_result: err=%b res=%0d, required 1/0", out_err, out_res);
    end
    checks++;
    if (crst_cnt - c0 != 1 || crst_cyc < s + int'(TIMEOUT) || crst_cyc > s + int'(TIMEOUT) + 2) begin
      errors++;
      $display("FAIL tmo_core_rst: pulses=%0d at start+%0d, required 1 at start+%0d..%0d",
               crst_cnt - c0, crst_cyc - s, TIMEOUT, TIMEOUT + 2);
    end
    never_done = 0;
    ready_mode = 1;
    drain();
    push_pair(40, 30, 0, n);
    drain();
    checks++;
    if (crst_cnt - c0 != 1) begin
      errors++; $display("FAIL tmo_followup: core_rst pulses=%0d, required 1", crst_cnt - c0);
    end
`else
    checks++;
    if (crst_cnt != 0) begin
      errors++; $display("FAIL no_tmo_core_rst: pulses=%0d, required 0", crst_cnt);
    end
`endif
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; out_ready = 1'b1;
    test_reset();
    test_basic();
    test_zero();
    test_back_to_back();
    test_out_hold();
    test_reset_mid();
    test_spurious_done();
    test_random();
    test_timeout();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
